// File: rtl/pad_ip_switch.sv
`default_nettype none
// =============================================================================
// Module   : pad_ip_switch
// Purpose  : Runtime pad-sharing switch between NUM_IP hard IP cores and the
//            chip pad ring, with a glitch-free quiesce/guard/reset/enable
//            handover, synchronised pad inputs and registered pad outputs.
// Revision : 1.0  initial release
// =============================================================================
module pad_ip_switch #(
  parameter int NUM_PADS     = 82,
  parameter int NUM_IP       = 4,
  parameter int SEL_W        = 2,
  parameter int DEFAULT_SEL  = 0,
  parameter int TEST_SEL     = 3,
  parameter int GUARD_CYCLES = 4,
  parameter int RST_HOLD     = 8,
  parameter int SYNC_STAGES  = 2
) (
  input  logic                         clk_pad,
  input  logic                         rst_pad,
  input  logic [SEL_W-1:0]             sel_req,
  input  logic                         sel_valid,
  output logic                         sel_ready,
  output logic                         sel_err,
  output logic                         busy,
  output logic [SEL_W-1:0]             active_sel,
  input  logic [NUM_PADS-1:0]          io_pad_i,
  output logic [NUM_PADS-1:0]          io_pad_o,
  output logic [NUM_PADS-1:0]          io_pad_oe,
  input  logic [NUM_IP*NUM_PADS-1:0]   ip_o,
  input  logic [NUM_IP*NUM_PADS-1:0]   ip_oe,
  output logic [NUM_IP*NUM_PADS-1:0]   ip_i,
  output logic [NUM_IP-1:0]            ip_rst,
  output logic                         test_mode_o
);

  localparam int CNT_MAX = (GUARD_CYCLES > RST_HOLD) ? GUARD_CYCLES : RST_HOLD;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);

  localparam logic [CNT_W-1:0] C_GUARD       = CNT_W'(GUARD_CYCLES);
  localparam logic [CNT_W-1:0] C_HOLD        = CNT_W'(RST_HOLD);
  localparam logic [CNT_W-1:0] C_ONE         = CNT_W'(1);
  localparam logic [SEL_W:0]   C_NUM_IP      = (SEL_W + 1)'(NUM_IP);
  localparam logic [SEL_W-1:0] C_DEFAULT_SEL = SEL_W'(DEFAULT_SEL);
  localparam logic [SEL_W-1:0] C_TEST_SEL    = SEL_W'(TEST_SEL);

  typedef enum logic [1:0] {
    ST_ACTIVE  = 2'd0,
    ST_QUIESCE = 2'd1,
    ST_SWITCH  = 2'd2,
    ST_RELEASE = 2'd3
  } state_t;

  state_t             r_state;
  state_t             w_state_nxt;
  logic [CNT_W-1:0]   r_cnt;
  logic [CNT_W-1:0]   w_cnt_nxt;
  logic [SEL_W-1:0]   r_target;
  logic [SEL_W-1:0]   w_target_nxt;
  logic [SEL_W-1:0]   r_active_sel;
  logic [SEL_W-1:0]   w_active_nxt;
  logic               r_sel_err;
  logic               w_err_nxt;
  logic               w_active;
  logic               w_req_oor;

  logic [NUM_PADS-1:0] r_pad_o;
  logic [NUM_PADS-1:0] r_pad_oe;
  logic [NUM_PADS-1:0] w_mux_o;
  logic [NUM_PADS-1:0] w_mux_oe;
  logic [NUM_PADS-1:0] r_sync [SYNC_STAGES];
  logic [NUM_PADS-1:0] w_sync_out;

  assign w_active  = (r_state == ST_ACTIVE);
  assign w_req_oor = ({1'b0, sel_req} >= C_NUM_IP);

  // ---------------------------------------------------------------------------
  // Switch sequencer
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk_pad or posedge rst_pad) begin
    if (rst_pad) begin
      r_state      <= ST_RELEASE;
      r_cnt        <= C_HOLD;
      r_target     <= C_DEFAULT_SEL;
      r_active_sel <= C_DEFAULT_SEL;
      r_sel_err    <= 1'b0;
    end else begin
      r_state      <= w_state_nxt;
      r_cnt        <= w_cnt_nxt;
      r_target     <= w_target_nxt;
      r_active_sel <= w_active_nxt;
      r_sel_err    <= w_err_nxt;
    end
  end

  always_comb begin
    w_state_nxt  = r_state;
    w_cnt_nxt    = r_cnt;
    w_target_nxt = r_target;
    w_active_nxt = r_active_sel;
    w_err_nxt    = 1'b0;
    case (r_state)
      ST_ACTIVE: begin
        if (sel_valid) begin
          if (w_req_oor) begin
            w_err_nxt = 1'b1;
          end else if (sel_req != r_active_sel) begin
            w_target_nxt = sel_req;
            w_cnt_nxt    = C_GUARD;
            w_state_nxt  = ST_QUIESCE;
          end
        end
      end
      ST_QUIESCE: begin
        if (r_cnt <= C_ONE) begin
          w_state_nxt = ST_SWITCH;
        end else begin
          w_cnt_nxt = r_cnt - C_ONE;
        end
      end
      ST_SWITCH: begin
        // Ownership moves only while every pad is already tri-stated.
        w_active_nxt = r_target;
        w_cnt_nxt    = C_HOLD;
        w_state_nxt  = ST_RELEASE;
      end
      ST_RELEASE: begin
        if (r_cnt <= C_ONE) begin
          w_state_nxt = ST_ACTIVE;
        end else begin
          w_cnt_nxt = r_cnt - C_ONE;
        end
      end
      default: begin
        w_state_nxt = ST_RELEASE;
        w_cnt_nxt   = C_HOLD;
      end
    endcase
  end

  assign sel_ready   = w_active;
  assign busy        = !w_active;
  assign sel_err     = r_sel_err;
  assign active_sel  = r_active_sel;
  assign test_mode_o = w_active && (r_active_sel == C_TEST_SEL);

  // ---------------------------------------------------------------------------
  // Pad output path: o and oe always come from the same owner in one register
  // ---------------------------------------------------------------------------
  always_comb begin
    w_mux_o  = '0;
    w_mux_oe = '0;
    for (int k = 0; k < NUM_IP; k++) begin
      if (r_active_sel == SEL_W'(k)) begin
        w_mux_o  = ip_o[k*NUM_PADS +: NUM_PADS];
        w_mux_oe = ip_oe[k*NUM_PADS +: NUM_PADS];
      end
    end
  end

  always_ff @(posedge clk_pad or posedge rst_pad) begin
    if (rst_pad) begin
      r_pad_o  <= '0;
      r_pad_oe <= '0;
    end else if (w_active) begin
      r_pad_o  <= w_mux_o;
      r_pad_oe <= w_mux_oe;
    end else begin
      r_pad_o  <= '0;
      r_pad_oe <= '0;
    end
  end

  assign io_pad_o  = r_pad_o;
  assign io_pad_oe = r_pad_oe;

  // ---------------------------------------------------------------------------
  // Pad input path
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk_pad or posedge rst_pad) begin
    if (rst_pad) begin
      for (int s = 0; s < SYNC_STAGES; s++) begin
        r_sync[s] <= '0;
      end
    end else begin
      r_sync[0] <= io_pad_i;
      for (int s = 1; s < SYNC_STAGES; s++) begin
        r_sync[s] <= r_sync[s-1];
      end
    end
  end

  assign w_sync_out = r_sync[SYNC_STAGES-1];

  // Only the owning IP, and only once released, sees pad inputs and leaves reset.
  always_comb begin
    ip_i   = '0;
    ip_rst = '1;
    for (int k = 0; k < NUM_IP; k++) begin
      if (w_active && (r_active_sel == SEL_W'(k))) begin
        ip_i[k*NUM_PADS +: NUM_PADS] = w_sync_out;
        ip_rst[k]                    = 1'b0;
      end
    end
  end

endmodule
`default_nettype wire
